// File: rtl/vram_write_buffer.sv
// Write-posting FIFO between the core's VRAM write port and the framebuffer port.
// Optional same-address tail coalescing is built when VRAM_WBUF_COALESCE_EN is defined.
module vram_write_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     vram_addr,
  input  logic [DATA_W-1:0]     vram_data,
  input  logic                  vram_wr,
  input  logic                  vram_en,
  input  logic                  fb_grant,
  output logic [ADDR_W-1:0]     fb_addr,
  output logic [DATA_W-1:0]     fb_data,
  output logic                  fb_we,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int                  DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [ADDR_W-1:0]     mem_addr [DEPTH];
  logic [DATA_W-1:0]     mem_data [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] tail_ptr;
  logic                  push_req;
  logic                  pop;
  logic                  coalesce;
  logic                  accept;
  logic                  drop;

  assign full     = (level == LVL_FULL);
  assign tail_ptr = wr_ptr - PTR_ONE;

  always_comb begin
    push_req = vram_en & vram_wr;
    pop      = fb_grant & (level != '0);
`ifdef VRAM_WBUF_COALESCE_EN
    // A lone entry leaving this edge can no longer absorb the write.
    coalesce = push_req & (level != '0) & (vram_addr == mem_addr[tail_ptr])
             & ~(pop & (level == LVL_ONE));
`else
    coalesce = 1'b0;
`endif
    accept   = push_req & ~coalesce & ((level != LVL_FULL) | pop);
    drop     = push_req & ~coalesce & ~accept;
  end

  // Storage is not reset; pointers and level define what is valid.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem_addr[wr_ptr] <= vram_addr;
      mem_data[wr_ptr] <= vram_data;
    end
`ifdef VRAM_WBUF_COALESCE_EN
    else if (coalesce) begin
      mem_data[tail_ptr] <= vram_data;
    end
`endif
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
      overflow <= 1'b0;
    end else begin
      fb_we <= pop;
      if (pop) begin
        fb_addr <= mem_addr[rd_ptr];
        fb_data <= mem_data[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      case ({accept, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/vram_write_buffer.md
Name: vram_write_buffer

Overview:
- Sits directly downstream of the CDM16 core's VRAM write port (vram_addr/vram_data/vram_wr/vram_en).
- Buffers CPU framebuffer writes in a FIFO and drains them into the framebuffer write port only when the video scanout grants access.
- The CPU has no stall input, so the block never back-pressures the core. On full it drops writes and flags overflow.
- Single clock domain, shared with the core.

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries
ADDR_W, 16, VRAM word address width
DATA_W, 16, VRAM data width

Ports:
clock  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
vram_addr  input  ADDR_W  write address from core
vram_data  input  DATA_W  write data from core
vram_wr  input  1  write qualifier from core
vram_en  input  1  access strobe from core
fb_grant  input  1  framebuffer port free this cycle (blanking/idle slot)
fb_addr  output  ADDR_W  framebuffer write address (registered)
fb_data  output  DATA_W  framebuffer write data (registered)
fb_we  output  1  framebuffer write strobe, one cycle per entry (registered)
level  output  DEPTH_LOG2+1  current FIFO occupancy (registered)
full  output  1  level == 2**DEPTH_LOG2
overflow  output  1  sticky: a write was dropped since reset or clear
ovf_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset (async, rst_n low): rd/wr pointers = 0, level = 0, fb_we = 0, fb_addr = 0, fb_data = 0, overflow = 0. All takes effect immediately, independent of clock. Entries in flight at reset are discarded.
- Push request: vram_en & vram_wr sampled at a rising edge. vram_en & !vram_wr is a read and is ignored. vram_wr without vram_en is ignored.
- Pop: occurs at an edge when fb_grant = 1 and the registered level != 0.
  - At that edge, fb_addr/fb_data load the head entry and fb_we goes to 1 for exactly one cycle.
  - Otherwise fb_we returns to 0. fb_addr/fb_data hold their last values.
- Push acceptance: accepted if level < DEPTH, or if a pop happens at the same edge (a full FIFO with a simultaneous pop accepts the push; level is unchanged).
- Dropped push: a push that is not accepted is dropped and sets overflow = 1 at that edge.
- overflow clear: ovf_clr = 1 clears overflow at the edge. If a drop occurs at the same edge, the set wins.
- Level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers: DEPTH_LOG2-bit, wrap modulo DEPTH.
- Ordering: strict FIFO; writes reach the framebuffer in CPU issue order.
- Latency: a push accepted at edge k into an empty FIFO with fb_grant high produces fb_we = 1 from edge k+1 to k+2 (one cycle minimum). No bypass from the input to fb_*.
- Throughput: one pop per cycle while fb_grant stays high.
- fb_grant low for any duration stalls draining with no loss; pushes continue until full.
- full is combinational from the registered level.

Optional Feature:
- Macro VRAM_WBUF_COALESCE_EN.
- Defined:
  - Condition: a push whose vram_addr equals the address of the most recently written (tail) entry, with that entry still in the FIFO and not being popped at the same edge.
  - Effect: the push overwrites the tail entry's data instead of allocating a new slot. Level and pointers are unchanged; no overflow is raised even when full.
  - If level == 1 and that entry is popped at the same edge, the push allocates normally.
- Undefined: every push allocates a new slot; no address compare logic is present.

Test Plan:
- Reset mid-operation: fill 5 entries, hold fb_grant = 0, pulse rst_n low → level = 0, fb_we = 0, overflow = 0 immediately. After release, no stale entry is ever written.
- Single write: push addr 0x1234 data 0xBEEF at edge k with fb_grant = 1 → fb_we = 1 in cycle k+1 only, with fb_addr = 0x1234 and fb_data = 0xBEEF.
- Fill, overflow and clear:
  - With fb_grant = 0, push 17 writes (DEPTH = 16) → level = 16, full = 1, overflow = 1.
  - Raise fb_grant → exactly 16 fb_we pulses in order, data 0..15.
  - Pulse ovf_clr → overflow = 0.
- Full with simultaneous push and pop: at level 16, push 0xAAAA while fb_grant = 1 → accepted, level stays 16, overflow stays 0. 0xAAAA is the 17th entry written out.
- Wrap-around: 40 writes with fb_grant toggling 1-of-3 cycles → all 40 appear on fb_* in order, with no duplicates and no loss.
- Coalescing (VRAM_WBUF_COALESCE_EN):
  - fb_grant = 0; push addr 0x10 data 1, then addr 0x10 data 2 → level = 1. Draining yields a single write of data 2.
  - Same stimulus with the macro undefined → level = 2, and the two writes drain in order.
